// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-port arbiter/sequencer for the core's single-port unified memory
module mem_port_arbiter #(
  parameter int MEM_BYTES = 1024,
  parameter int ARB_MODE  = 0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [31:0] if_req_addr,
  output logic        if_rsp_valid,
  input  logic        if_rsp_ready,
  input  logic        d_req_valid,
  output logic        d_req_ready,
  input  logic [31:0] d_req_addr,
  input  logic        d_req_we,
  input  logic [31:0] d_req_wdata,
  output logic        d_rsp_valid,
  input  logic        d_rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic        PORT_IF  = 1'b0;
  localparam logic        PORT_D   = 1'b1;
  localparam logic [31:0] MAX_ADDR = 32'(MEM_BYTES - 4);

  state_t      r_state;
  state_t      w_next;
  logic        r_gnt;
  logic        r_we;
  logic        r_err;
  logic        r_last_grant;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;

  logic        w_idle;
  logic        w_pick_d;
  logic        w_hs;
  logic [31:0] w_req_addr;
  logic        w_req_err;
  logic        w_rsp_ready;

  // Data wins when alone; on contention round-robin favours the port not served last.
  assign w_pick_d = d_req_valid &&
                    (!if_req_valid || (ARB_MODE == 0 && r_last_grant == PORT_IF));

  assign w_idle       = (r_state == IDLE) && resetn;
  assign if_req_ready = w_idle && if_req_valid && !w_pick_d;
  assign d_req_ready  = w_idle && d_req_valid && w_pick_d;
  assign w_hs         = if_req_ready || d_req_ready;

  assign w_req_addr  = w_pick_d ? d_req_addr : if_req_addr;
  assign w_req_err   = (w_req_addr[1:0] != 2'b00) || (w_req_addr > MAX_ADDR);
  assign w_rsp_ready = (r_gnt == PORT_D) ? d_rsp_ready : if_rsp_ready;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_hs) w_next = w_req_err ? RESP : ACCESS;
      ACCESS:  w_next = RESP;
      RESP:    if (w_rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state      <= IDLE;
      r_gnt        <= PORT_IF;
      r_we         <= 1'b0;
      r_err        <= 1'b0;
      r_addr       <= 32'h0;
      r_wdata      <= 32'h0;
      r_last_grant <= PORT_D;
    end else begin
      r_state <= w_next;
      if (w_hs) begin
        r_gnt        <= w_pick_d;
        r_we         <= w_pick_d && d_req_we;
        r_err        <= w_req_err;
        r_addr       <= w_req_addr;
        r_wdata      <= w_pick_d ? d_req_wdata : 32'h0;
        r_last_grant <= w_pick_d;
      end
    end
  end

  assign mem_read  = (r_state == ACCESS) && !r_we;
  assign mem_write = (r_state == ACCESS) && r_we;
  assign mem_addr  = (r_state == ACCESS) ? r_addr : 32'h0;
  assign mem_wdata = (r_state == ACCESS) ? r_wdata : 32'h0;

  // The memory holds its read register outside ACCESS, so rdata stays stable while waiting.
  assign if_rsp_valid = (r_state == RESP) && (r_gnt == PORT_IF);
  assign d_rsp_valid  = (r_state == RESP) && (r_gnt == PORT_D);
  assign rsp_err      = (r_state == RESP) && r_err;
  assign rsp_rdata    = ((r_state == RESP) && !r_err && !r_we) ? mem_rdata : 32'h0;
  assign busy         = (r_state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        if_req_valid, if_rsp_ready, d_req_valid, d_req_we, d_rsp_ready;
  logic [31:0] if_req_addr, d_req_addr, d_req_wdata;
  logic        if_req_ready, if_rsp_valid, d_req_ready, d_rsp_valid, rsp_err;
  logic        mem_read, mem_write, busy;
  logic [31:0] rsp_rdata, mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 32'h0;

  logic        if_req_valid2, d_req_valid2;
  logic        if_req_ready2, if_rsp_valid2, d_req_ready2, d_rsp_valid2, rsp_err2;
  logic        mem_read2, mem_write2, busy2;
  logic [31:0] rsp_rdata2, mem_addr2, mem_wdata2;
  logic [31:0] mem_rdata2 = 32'h0;

  logic [31:0] mem [0:255];
  int          n_checks = 0;
  int          n_fail = 0;
  int          wcnt = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MEM_BYTES(1024), .ARB_MODE(0)) dut (
    .clk(clk), .resetn(resetn),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_ready(if_rsp_ready),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
    .d_req_we(d_req_we), .d_req_wdata(d_req_wdata),
    .d_rsp_valid(d_rsp_valid), .d_rsp_ready(d_rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_port_arbiter #(.MEM_BYTES(1024), .ARB_MODE(1)) dut_fixed (
    .clk(clk), .resetn(resetn),
    .if_req_valid(if_req_valid2), .if_req_ready(if_req_ready2), .if_req_addr(32'h0),
    .if_rsp_valid(if_rsp_valid2), .if_rsp_ready(1'b1),
    .d_req_valid(d_req_valid2), .d_req_ready(d_req_ready2), .d_req_addr(32'h4),
    .d_req_we(1'b0), .d_req_wdata(32'h0),
    .d_rsp_valid(d_rsp_valid2), .d_rsp_ready(1'b1),
    .rsp_rdata(rsp_rdata2), .rsp_err(rsp_err2),
    .mem_read(mem_read2), .mem_write(mem_write2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
    .mem_rdata(mem_rdata2), .busy(busy2)
  );

  always @(posedge clk) begin
    if (resetn) begin
      if (mem_read) mem_rdata <= mem[mem_addr[9:2]];
      if (mem_write) begin
        mem[mem_addr[9:2]] <= mem_wdata;
        wcnt <= wcnt + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called just after a rising edge; returns just after the edge that retires the response.
  task automatic access(input string tag, input bit port, input logic [31:0] addr, input bit we,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata, input bit exp_err);
    int n, lat, rd, wr;
    bit got;
    logic [31:0] saddr;
    if (port) begin
      d_req_valid = 1'b1; d_req_addr = addr; d_req_we = we; d_req_wdata = wdata;
    end else begin
      if_req_valid = 1'b1; if_req_addr = addr;
    end
    n = 0; got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      got = port ? d_req_ready : if_req_ready;
      n++;
      if (!got) begin @(posedge clk); #1; end
    end
    check({tag, "_hs"}, 32'(got), 32'd1);
    @(posedge clk); #1;
    if_req_valid = 1'b0; d_req_valid = 1'b0;
    lat = 0; rd = 0; wr = 0; saddr = 32'h0; got = 1'b0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (mem_read)  begin rd++; saddr = mem_addr; end
      if (mem_write) begin wr++; saddr = mem_addr; end
      got = port ? d_rsp_valid : if_rsp_valid;
      if (!got) begin @(posedge clk); #1; end
    end
    check({tag, "_lat"}, 32'(lat), exp_err ? 32'd1 : 32'd2);
    check({tag, "_rd"}, 32'(rd), (!exp_err && !we) ? 32'd1 : 32'd0);
    check({tag, "_wr"}, 32'(wr), (!exp_err && we) ? 32'd1 : 32'd0);
    if (!exp_err) check({tag, "_maddr"}, saddr, addr);
    check({tag, "_rdata"}, rsp_rdata, exp_rdata);
    check({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
    @(posedge clk); #1;
  endtask

  initial begin
    int c1, c2, w0;
    logic [5:0] g1, g2;

    for (int i = 0; i < 256; i++) mem[i] = 32'hA5A50000 | 32'(i);
    mem[0] = 32'h00002083;
    mem[1] = 32'h00108133;
    mem[2] = 32'h11111111;

    resetn = 1'b0;
    if_req_valid = 1'b1; if_req_addr = 32'h0; if_rsp_ready = 1'b1;
    d_req_valid = 1'b1; d_req_addr = 32'h4; d_req_we = 1'b0; d_req_wdata = 32'h0; d_rsp_ready = 1'b1;
    if_req_valid2 = 1'b0; d_req_valid2 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_if_ready", 32'(if_req_ready), 32'd0);
    check("rst_d_ready", 32'(d_req_ready), 32'd0);
    check("rst_rsp_valid", {30'h0, if_rsp_valid, d_rsp_valid}, 32'd0);
    check("rst_rsp", {31'h0, rsp_err} | rsp_rdata, 32'd0);
    check("rst_strobes", {30'h0, mem_read, mem_write}, 32'd0);
    check("rst_maddr", mem_addr | mem_wdata, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1; if_req_valid = 1'b0; d_req_valid = 1'b0;

    access("fetch0", 1'b0, 32'h0, 1'b0, 32'h0, 32'h00002083, 1'b0);
    w0 = wcnt;
    access("st100", 1'b1, 32'h100, 1'b1, 32'hDEADBEEF, 32'h0, 1'b0);
    access("ld100", 1'b1, 32'h100, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0);
    check("st_once", 32'(wcnt - w0), 32'd1);
    access("ld102", 1'b1, 32'h102, 1'b0, 32'h0, 32'h0, 1'b1);
    access("ld400", 1'b1, 32'h400, 1'b0, 32'h0, 32'h0, 1'b1);
    access("ld3fc", 1'b1, 32'h3FC, 1'b0, 32'h0, 32'hA5A500FF, 1'b0);
    access("fetch2", 1'b0, 32'h2, 1'b0, 32'h0, 32'h0, 1'b1);
    access("ldalias", 1'b1, 32'h10000100, 1'b0, 32'h0, 32'h0, 1'b1);

    // Contention: both ports held valid on both instances.
    c1 = 0; c2 = 0; g1 = 6'h0; g2 = 6'h3F;
    if_req_valid = 1'b1; if_req_addr = 32'h0;
    d_req_valid = 1'b1; d_req_addr = 32'h4; d_req_we = 1'b0;
    if_req_valid2 = 1'b1; d_req_valid2 = 1'b1;
    for (int cyc = 0; cyc < 60 && (c1 < 6 || c2 < 6); cyc++) begin
      @(negedge clk);
      if (c1 < 6 && (if_req_ready || d_req_ready)) begin g1[c1] = d_req_ready; c1++; end
      if (c2 < 6 && (if_req_ready2 || d_req_ready2)) begin g2[c2] = d_req_ready2; c2++; end
      @(posedge clk); #1;
      if (c1 == 6) begin if_req_valid = 1'b0; d_req_valid = 1'b0; end
      if (c2 == 6) begin if_req_valid2 = 1'b0; d_req_valid2 = 1'b0; end
    end
    check("rr_count", 32'(c1), 32'd6);
    check("rr_seq", 32'(g1), 32'h2A);
    check("fixed_count", 32'(c2), 32'd6);
    check("fixed_seq", 32'(g2), 32'h00);
    for (int cyc = 0; cyc < 20 && (busy || busy2); cyc++) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("drain_busy", {30'h0, busy, busy2}, 32'd0);
    @(posedge clk); #1;

    // Data load with its response held off while a fetch waits.
    d_req_valid = 1'b1; d_req_addr = 32'h4; d_req_we = 1'b0; d_rsp_ready = 1'b0;
    @(negedge clk);
    check("hold_hs", 32'(d_req_ready), 32'd1);
    @(posedge clk); #1;
    d_req_valid = 1'b0; if_req_valid = 1'b1; if_req_addr = 32'h0;
    @(negedge clk);
    check("hold_acc_ifrdy", 32'(if_req_ready), 32'd0);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("hold_valid", 32'(d_rsp_valid), 32'd1);
      check("hold_rdata", rsp_rdata, 32'h00108133);
      check("hold_ifrdy", 32'(if_req_ready), 32'd0);
    end
    @(posedge clk); #1;
    d_rsp_ready = 1'b1;
    @(negedge clk);
    check("rel_valid", 32'(d_rsp_valid), 32'd1);
    check("rel_ifrdy", 32'(if_req_ready), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("after_ifrdy", 32'(if_req_ready), 32'd1);
    @(posedge clk); #1;
    if_req_valid = 1'b0;
    for (int cyc = 0; cyc < 20 && !if_rsp_valid; cyc++) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("after_fetch_valid", 32'(if_rsp_valid), 32'd1);
    check("after_fetch_rdata", rsp_rdata, 32'h00002083);
    @(posedge clk); #1;

    // Reset during the ACCESS cycle of a store.
    d_req_valid = 1'b1; d_req_addr = 32'h8; d_req_we = 1'b1; d_req_wdata = 32'hCAFEF00D;
    @(negedge clk);
    check("rststore_hs", 32'(d_req_ready), 32'd1);
    @(posedge clk); #1;
    d_req_valid = 1'b0; d_req_we = 1'b0; resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    check("rststore_busy", 32'(busy), 32'd0);
    check("rststore_rsp", 32'(d_rsp_valid), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("rststore_norsp", 32'(d_rsp_valid), 32'd0);
    end
    @(posedge clk); #1;
    access("ld8", 1'b1, 32'h8, 1'b0, 32'h0, 32'h11111111, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
